// File: rtl/clock_time_controller.sv
// HH:MM:SS BCD time keeper with 1 Hz prescaler and a two-button set-hour/set-minute mode FSM.
// The mode output is the raw FSM state, so checkers can bind to it directly.
module clock_time_controller #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_u,
    output logic [3:0] sec_t,
    output logic [3:0] min_u,
    output logic [3:0] min_t,
    output logic [3:0] hr_u,
    output logic [3:0] hr_t,
    output logic [1:0] mode,
    output logic       blink,
    output logic       tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } state_t;

    state_t        r_state, w_state_next;
    logic [PW-1:0] r_presc, w_presc_next;
    logic          r_mode_prev, r_inc_prev;
    logic          r_blink, w_blink_next;
    logic          r_tick;
    logic [3:0]    r_sec_u, r_sec_t, r_min_u, r_min_t, r_hr_u, r_hr_t;
    logic [3:0]    w_sec_u_n, w_sec_t_n, w_min_u_n, w_min_t_n, w_hr_u_n, w_hr_t_n;
    logic          w_press_mode, w_press_inc, w_tick_now;
    logic          w_min_inc, w_hr_inc;

    assign w_press_mode = btn_mode & ~r_mode_prev;
    assign w_press_inc  = btn_inc & ~r_inc_prev;
    assign w_tick_now   = (r_presc == PRESC_MAX);

    always_comb begin
        w_state_next = r_state;
        if (w_press_mode) begin
            case (r_state)
                ST_RUN:      w_state_next = ST_SET_HOUR;
                ST_SET_HOUR: w_state_next = ST_SET_MIN;
                default:     w_state_next = ST_RUN;
            endcase
        end
    end

    // Leaving SET_MIN restarts the second so the user's set time starts on a full second.
    always_comb begin
        w_presc_next = r_presc + PW'(1);
        if (w_tick_now || (r_state == ST_SET_MIN && w_press_mode)) begin
            w_presc_next = '0;
        end
    end

    always_comb begin
        w_blink_next = r_blink;
        if (w_state_next == ST_RUN) begin
            w_blink_next = 1'b0;
        end else if (w_state_next != r_state) begin
            w_blink_next = 1'b1;
        end else if (w_tick_now) begin
            w_blink_next = ~r_blink;
        end
    end

    // Digit chain: the minute carry only ripples into hours while running.
    always_comb begin
        w_sec_u_n = r_sec_u;
        w_sec_t_n = r_sec_t;
        w_min_u_n = r_min_u;
        w_min_t_n = r_min_t;
        w_hr_u_n  = r_hr_u;
        w_hr_t_n  = r_hr_t;
        w_min_inc = 1'b0;
        w_hr_inc  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_tick_now) begin
                    if (r_sec_u != 4'd9) begin
                        w_sec_u_n = r_sec_u + 4'd1;
                    end else begin
                        w_sec_u_n = 4'd0;
                        if (r_sec_t != 4'd5) begin
                            w_sec_t_n = r_sec_t + 4'd1;
                        end else begin
                            w_sec_t_n = 4'd0;
                            w_min_inc = 1'b1;
                        end
                    end
                end
            end
            ST_SET_HOUR: w_hr_inc = w_press_inc & ~w_press_mode;
            ST_SET_MIN: begin
                if (w_press_mode) begin
                    w_sec_u_n = 4'd0;
                    w_sec_t_n = 4'd0;
                end else begin
                    w_min_inc = w_press_inc;
                end
            end
            default: ;
        endcase
        if (w_min_inc) begin
            if (r_min_u != 4'd9) begin
                w_min_u_n = r_min_u + 4'd1;
            end else begin
                w_min_u_n = 4'd0;
                if (r_min_t != 4'd5) begin
                    w_min_t_n = r_min_t + 4'd1;
                end else begin
                    w_min_t_n = 4'd0;
                    w_hr_inc  = (r_state == ST_RUN);
                end
            end
        end
        if (w_hr_inc) begin
            if (r_hr_t == 4'd2 && r_hr_u == 4'd3) begin
                w_hr_u_n = 4'd0;
                w_hr_t_n = 4'd0;
            end else if (r_hr_u == 4'd9) begin
                w_hr_u_n = 4'd0;
                w_hr_t_n = r_hr_t + 4'd1;
            end else begin
                w_hr_u_n = r_hr_u + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_presc     <= '0;
            r_mode_prev <= 1'b0;
            r_inc_prev  <= 1'b0;
            r_blink     <= 1'b0;
            r_tick      <= 1'b0;
            r_sec_u     <= 4'd0;
            r_sec_t     <= 4'd0;
            r_min_u     <= 4'd0;
            r_min_t     <= 4'd0;
            r_hr_u      <= 4'd0;
            r_hr_t      <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_presc     <= w_presc_next;
            r_mode_prev <= btn_mode;
            r_inc_prev  <= btn_inc;
            r_blink     <= w_blink_next;
            r_tick      <= w_tick_now;
            r_sec_u     <= w_sec_u_n;
            r_sec_t     <= w_sec_t_n;
            r_min_u     <= w_min_u_n;
            r_min_t     <= w_min_t_n;
            r_hr_u      <= w_hr_u_n;
            r_hr_t      <= w_hr_t_n;
        end
    end

    assign sec_u = r_sec_u;
    assign sec_t = r_sec_t;
    assign min_u = r_min_u;
    assign min_t = r_min_t;
    assign hr_u  = r_hr_u;
    assign hr_t  = r_hr_t;
    assign mode  = r_state;
    assign blink = r_blink;
    assign tick  = r_tick;

endmodule
